// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly in front of the unified Memory
// block. It owns the program counter, drives the memory address bus in read
// mode, absorbs the memory's one-cycle registered read latency and presents
// fetched words to decode through a valid/ready handshake backed by a
// two-entry skid FIFO. Branch redirects flush everything in flight.
//
// Ports
//   clk            in   rising-edge system clock
//   rst            in   synchronous active-high reset (highest priority)
//   mem_addr       out  address to Memory; always equals the current pc
//   mem_we         out  Memory write enable; tied low, fetch never writes
//   mem_rdata      in   Memory read data = mem[address of previous cycle]
//   redirect_valid in   taken branch/jump this cycle
//   redirect_pc    in   redirect target address
//   instr_valid    out  instr_data/instr_pc hold a word for decode
//   instr_ready    in   decode accepts the presented word this cycle
//   instr_data     out  fetched instruction word (FIFO head)
//   instr_pc       out  address the head word was fetched from
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int data_length = 32,
   parameter int mem_length  = 32,
   parameter int reset_pc    = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic [$clog2(mem_length)-1:0] mem_addr,
   output logic                          mem_we,
   input  logic [data_length-1:0]        mem_rdata,
   input  logic                          redirect_valid,
   input  logic [$clog2(mem_length)-1:0] redirect_pc,
   output logic                          instr_valid,
   input  logic                          instr_ready,
   output logic [data_length-1:0]        instr_data,
   output logic [$clog2(mem_length)-1:0] instr_pc
);

   localparam int              aw         = $clog2(mem_length);
   localparam logic [aw-1:0]   last_pc    = aw'(mem_length - 1);
   localparam logic [aw-1:0]   reset_pc_c = aw'(reset_pc);

   // Sequential address with explicit wrap so non-power-of-2 sizes work.
   function automatic logic [aw-1:0] next_pc(input logic [aw-1:0] pc);
      logic [aw-1:0] nxt;
      if (pc == last_pc) begin
         nxt = {aw{1'b0}};
      end else begin
         nxt = pc + aw'(1);
      end
      return nxt;
   endfunction

   // Architectural state
   logic [aw-1:0]          pc_q,          pc_d;
   logic                   inflight_q,    inflight_d;
   logic [aw-1:0]          inflight_pc_q, inflight_pc_d;
   logic [1:0]             occ_q,         occ_d;
   logic                   valid_q,       valid_d;
   // FIFO entry 0 is always the head; entry 1 is the skid slot.
   logic [data_length-1:0] e0_data_q,     e0_data_d;
   logic [aw-1:0]          e0_pc_q,       e0_pc_d;
   logic [data_length-1:0] e1_data_q,     e1_data_d;
   logic [aw-1:0]          e1_pc_q,       e1_pc_d;

   // Per-cycle control
   logic                   pop_s;
   logic                   push_s;
   logic                   issue_s;
   logic [2:0]             need_s;

   // Handshake, capture and issue decisions for the current cycle.
   always_comb begin
      pop_s  = valid_q & instr_ready;
      push_s = inflight_q & ~redirect_valid;
      // Words that would still be owed to decode after this cycle's pop;
      // issuing is safe only if at most one slot is already spoken for,
      // which keeps the 2-entry FIFO from ever overflowing.
      need_s  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
      issue_s = ~rst & ~redirect_valid & (need_s <= 3'd1);
   end

   // Program counter and inflight tracking.
   always_comb begin
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      if (redirect_valid) begin
         // Outstanding read is dropped; next issue starts at the target.
         pc_d       = redirect_pc;
         inflight_d = 1'b0;
      end else if (issue_s) begin
         pc_d          = next_pc(pc_q);
         inflight_d    = 1'b1;
         inflight_pc_d = pc_q;
      end else begin
         pc_d       = pc_q;
         inflight_d = 1'b0;
      end
   end

   // Skid FIFO update: flush on redirect, otherwise shift/fill.
   always_comb begin
      occ_d     = occ_q;
      e0_data_d = e0_data_q;
      e0_pc_d   = e0_pc_q;
      e1_data_d = e1_data_q;
      e1_pc_d   = e1_pc_q;
      if (redirect_valid) begin
         // A pop in this cycle still completes for decode; its word and
         // everything behind it is discarded here.
         occ_d     = 2'd0;
         e0_data_d = {data_length{1'b0}};
         e0_pc_d   = {aw{1'b0}};
         e1_data_d = {data_length{1'b0}};
         e1_pc_d   = {aw{1'b0}};
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               case (occ_q)
                  2'd0: begin
                     e0_data_d = mem_rdata;
                     e0_pc_d   = inflight_pc_q;
                     occ_d     = 2'd1;
                  end
                  2'd1: begin
                     e1_data_d = mem_rdata;
                     e1_pc_d   = inflight_pc_q;
                     occ_d     = 2'd2;
                  end
                  default: begin
                     // Full: unreachable under the issue rule (asserted).
                     occ_d = occ_q;
                  end
               endcase
            end
            2'b01: begin
               e0_data_d = e1_data_q;
               e0_pc_d   = e1_pc_q;
               e1_data_d = {data_length{1'b0}};
               e1_pc_d   = {aw{1'b0}};
               occ_d     = occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  e0_data_d = mem_rdata;
                  e0_pc_d   = inflight_pc_q;
               end else begin
                  e0_data_d = e1_data_q;
                  e0_pc_d   = e1_pc_q;
                  e1_data_d = mem_rdata;
                  e1_pc_d   = inflight_pc_q;
               end
               occ_d = occ_q;
            end
            default: begin
               occ_d = occ_q;
            end
         endcase
      end
   end

   // Output valid is registered alongside the occupancy it mirrors.
   always_comb begin
      valid_d = (occ_d != 2'd0);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= reset_pc_c;
         inflight_q    <= 1'b0;
         inflight_pc_q <= {aw{1'b0}};
         occ_q         <= 2'd0;
         valid_q       <= 1'b0;
         e0_data_q     <= {data_length{1'b0}};
         e0_pc_q       <= {aw{1'b0}};
         e1_data_q     <= {data_length{1'b0}};
         e1_pc_q       <= {aw{1'b0}};
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         occ_q         <= occ_d;
         valid_q       <= valid_d;
         e0_data_q     <= e0_data_d;
         e0_pc_q       <= e0_pc_d;
         e1_data_q     <= e1_data_d;
         e1_pc_q       <= e1_pc_d;
      end
   end

   assign mem_addr    = pc_q;
   assign mem_we      = 1'b0;
   assign instr_valid = valid_q;
   assign instr_data  = e0_data_q;
   assign instr_pc    = e0_pc_q;

   // A push into a full FIFO without a matching pop would lose a word.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push_s && !pop_s && !redirect_valid && (occ_q == 2'd2)))
      else $error("fetch_unit: skid FIFO overflow");

   // Occupancy encoding 3 is never legal for a 2-entry FIFO.
   a_occ_range: assert property (@(posedge clk) disable iff (rst)
      occ_q != 2'd3)
      else $error("fetch_unit: illegal FIFO occupancy");

   // Registered valid must always agree with occupancy.
   a_valid_occ: assert property (@(posedge clk) disable iff (rst)
      valid_q == (occ_q != 2'd0))
      else $error("fetch_unit: valid/occupancy disagreement");

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. Two instances: the default 32-word
// configuration and a 20-word configuration starting at pc 18 for the
// non-power-of-2 wrap. Each instance reads from a registered memory model
// whose word at address i is a fixed base plus i, so every expected word
// follows directly from the expected pc.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance: mem_length = 32, reset_pc = 0
   logic        rst;
   logic [4:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic        redirect_valid;
   logic [4:0]  redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [4:0]  instr_pc;

   // Second instance: mem_length = 20, reset_pc = 18
   logic        rst2;
   logic [4:0]  mem_addr2;
   logic        mem_we2;
   logic [31:0] mem_rdata2;
   logic        instr_valid2;
   logic        instr_ready2;
   logic [31:0] instr_data2;
   logic [4:0]  instr_pc2;

   logic [31:0] mem  [0:31];
   logic [31:0] mem2 [0:19];

   int checks   = 0;
   int failures = 0;

   fetch_unit #(.data_length(32), .mem_length(32), .reset_pc(0)) u_dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc)
   );

   fetch_unit #(.data_length(32), .mem_length(20), .reset_pc(18)) u_dut2 (
      .clk(clk), .rst(rst2), .mem_addr(mem_addr2), .mem_we(mem_we2),
      .mem_rdata(mem_rdata2), .redirect_valid(1'b0),
      .redirect_pc(5'd0), .instr_valid(instr_valid2),
      .instr_ready(instr_ready2), .instr_data(instr_data2), .instr_pc(instr_pc2)
   );

   // Registered-read memory models (1-cycle latency).
   always @(posedge clk) mem_rdata  <= mem[mem_addr];
   always @(posedge clk) mem_rdata2 <= mem2[mem_addr2];

   // Advance one cycle; inputs driven and outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset for one edge, release, then stream n cycles with ready high.
   // Afterwards in cycle n: mem_addr = n, head pc = n-2 (for n >= 2).
   task automatic restart(input int n);
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 5'd0; instr_ready = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      logic [31:0] exp_d;
      rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 5'd0;
      tick(); tick();
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
      checks++; if (instr_data !== 32'd0) begin failures++; $display("FAIL reset_data: got %h expected 0", instr_data); end
      checks++; if (instr_pc !== 5'd0) begin failures++; $display("FAIL reset_pc: got %0d expected 0", instr_pc); end
      checks++; if (mem_addr !== 5'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", mem_we); end
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         checks++; if (mem_addr !== 5'(c)) begin failures++; $display("FAIL first_addr c%0d: got %0d expected %0d", c, mem_addr, c); end
         checks++; if (instr_valid !== (c >= 2)) begin failures++; $display("FAIL first_valid c%0d: got %b expected %b", c, instr_valid, (c >= 2)); end
         if (c >= 2) begin
            exp_d = 32'hA000_0000 + 32'(c - 2);
            checks++; if (instr_pc !== 5'(c - 2)) begin failures++; $display("FAIL first_pc c%0d: got %0d expected %0d", c, instr_pc, c - 2); end
            checks++; if (instr_data !== exp_d) begin failures++; $display("FAIL first_data c%0d: got %h expected %h", c, instr_data, exp_d); end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_d;
      restart(6);                       // head pc 4, mem_addr 6
      instr_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid c%0d: got %b expected 1", c, instr_valid); end
         checks++; if (instr_pc !== 5'd4) begin failures++; $display("FAIL stall_pc c%0d: got %0d expected 4", c, instr_pc); end
         checks++; if (instr_data !== 32'hA000_0004) begin failures++; $display("FAIL stall_data c%0d: got %h expected a0000004", c, instr_data); end
         checks++; if (mem_addr !== 5'd6) begin failures++; $display("FAIL stall_addr c%0d: got %0d expected 6", c, mem_addr); end
         tick();
      end
      instr_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         exp_d = 32'hA000_0000 + 32'(4 + k);
         checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL resume_valid k%0d: got %b expected 1", k, instr_valid); end
         checks++; if (instr_pc !== 5'(4 + k)) begin failures++; $display("FAIL resume_pc k%0d: got %0d expected %0d", k, instr_pc, 4 + k); end
         checks++; if (instr_data !== exp_d) begin failures++; $display("FAIL resume_data k%0d: got %h expected %h", k, instr_data, exp_d); end
         checks++; if (mem_addr !== 5'(6 + k)) begin failures++; $display("FAIL resume_addr k%0d: got %0d expected %0d", k, mem_addr, 6 + k); end
         tick();
      end
   endtask

   // Redirect at cycle R, then check R+1 .. R+1+n-1 against exp tables.
   task automatic test_redirect_to(input string nm, input logic [4:0] target,
                                   input int start_cycle);
      logic [4:0]  exp_pc;
      logic [4:0]  exp_a;
      logic [31:0] exp_d;
      restart(start_cycle);
      redirect_valid = 1'b1; redirect_pc = target;
      tick();
      redirect_valid = 1'b0; redirect_pc = 5'd0;
      for (int k = 1; k <= 6; k++) begin           // cycle R+k
         exp_a = target + 5'(k - 1);              // 5-bit wrap = mod 32
         checks++; if (mem_addr !== exp_a) begin failures++; $display("FAIL %s_addr R+%0d: got %0d expected %0d", nm, k, mem_addr, exp_a); end
         checks++; if (instr_valid !== (k >= 3)) begin failures++; $display("FAIL %s_valid R+%0d: got %b expected %b", nm, k, instr_valid, (k >= 3)); end
         if (k >= 3) begin
            exp_pc = target + 5'(k - 3);
            exp_d  = 32'hA000_0000 + 32'(exp_pc);
            checks++; if (instr_pc !== exp_pc) begin failures++; $display("FAIL %s_pc R+%0d: got %0d expected %0d", nm, k, instr_pc, exp_pc); end
            checks++; if (instr_data !== exp_d) begin failures++; $display("FAIL %s_data R+%0d: got %h expected %h", nm, k, instr_data, exp_d); end
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      // cycle 5: pc = 5, head 3, word 4 inflight; both must be dropped
      restart(5);
      checks++; if (mem_addr !== 5'd5) begin failures++; $display("FAIL redir_pre_addr: got %0d expected 5", mem_addr); end
      test_redirect_to("redir", 5'd20, 5);
   endtask

   task automatic test_wrap();
      test_redirect_to("wrap", 5'd30, 4);
   endtask

   task automatic test_back_to_back();
      restart(4);
      redirect_valid = 1'b1; redirect_pc = 5'd10;
      tick();                                       // R+1
      redirect_pc = 5'd12;
      checks++; if (mem_addr !== 5'd10) begin failures++; $display("FAIL b2b_addr R+1: got %0d expected 10", mem_addr); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid R+1: got %b expected 0", instr_valid); end
      tick();                                       // R+2
      redirect_valid = 1'b0; redirect_pc = 5'd0;
      checks++; if (mem_addr !== 5'd12) begin failures++; $display("FAIL b2b_addr R+2: got %0d expected 12", mem_addr); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid R+2: got %b expected 0", instr_valid); end
      tick();                                       // R+3
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid R+3: got %b expected 0", instr_valid); end
      tick();                                       // R+4
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid R+4: got %b expected 1", instr_valid); end
      checks++; if (instr_pc !== 5'd12) begin failures++; $display("FAIL b2b_pc R+4: got %0d expected 12", instr_pc); end
      checks++; if (instr_data !== 32'hA000_000C) begin failures++; $display("FAIL b2b_data R+4: got %h expected a000000c", instr_data); end
      tick();                                       // R+5
      checks++; if (instr_pc !== 5'd13) begin failures++; $display("FAIL b2b_pc R+5: got %0d expected 13", instr_pc); end
   endtask

   task automatic test_reset_mid();
      restart(4);                                   // head 2
      instr_ready = 1'b0;
      tick(); tick(); tick();                       // FIFO full, head 2
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'd2) begin failures++; $display("FAIL mid_pre: got valid %b pc %0d expected 1 / 2", instr_valid, instr_pc); end
      rst = 1'b1;
      tick();
      rst = 1'b0; instr_ready = 1'b1;
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b expected 0", instr_valid); end
      checks++; if (instr_data !== 32'd0) begin failures++; $display("FAIL mid_data: got %h expected 0", instr_data); end
      checks++; if (mem_addr !== 5'd0) begin failures++; $display("FAIL mid_addr: got %0d expected 0", mem_addr); end
      tick();
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL mid_valid c1: got %b expected 0", instr_valid); end
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 5'd0) begin failures++; $display("FAIL mid_restart c2: got valid %b pc %0d expected 1 / 0", instr_valid, instr_pc); end
      checks++; if (instr_data !== 32'hA000_0000) begin failures++; $display("FAIL mid_restart_data: got %h expected a0000000", instr_data); end
      tick();
      checks++; if (instr_pc !== 5'd1) begin failures++; $display("FAIL mid_restart c3: got %0d expected 1", instr_pc); end
   endtask

   task automatic test_npow2();
      logic [4:0]  exp_pc [0:3];
      logic [31:0] exp_d;
      exp_pc[0] = 5'd18; exp_pc[1] = 5'd19; exp_pc[2] = 5'd0; exp_pc[3] = 5'd1;
      checks++; if (mem_addr2 !== 5'd18) begin failures++; $display("FAIL np2_reset_addr: got %0d expected 18", mem_addr2); end
      checks++; if (instr_valid2 !== 1'b0) begin failures++; $display("FAIL np2_reset_valid: got %b expected 0", instr_valid2); end
      rst2 = 1'b0;
      tick();                                       // cycle 1
      checks++; if (mem_addr2 !== 5'd19) begin failures++; $display("FAIL np2_addr c1: got %0d expected 19", mem_addr2); end
      tick();                                       // cycle 2
      checks++; if (mem_addr2 !== 5'd0) begin failures++; $display("FAIL np2_addr c2: got %0d expected 0", mem_addr2); end
      for (int k = 0; k < 4; k++) begin
         exp_d = 32'hB000_0000 + 32'(exp_pc[k]);
         checks++; if (instr_valid2 !== 1'b1 || instr_pc2 !== exp_pc[k]) begin failures++; $display("FAIL np2_pc k%0d: got valid %b pc %0d expected 1 / %0d", k, instr_valid2, instr_pc2, exp_pc[k]); end
         checks++; if (instr_data2 !== exp_d) begin failures++; $display("FAIL np2_data k%0d: got %h expected %h", k, instr_data2, exp_d); end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i]  = 32'hA000_0000 + 32'(i);
      for (int i = 0; i < 20; i++) mem2[i] = 32'hB000_0000 + 32'(i);
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 5'd0; instr_ready = 1'b0;
      rst2 = 1'b1; instr_ready2 = 1'b1;
      test_reset();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_npow2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
